// File: rtl/fa4_pkg.sv
// Shared types for the FA4 serial execute engine: ALU opcodes, sequencer states,
// the default datapath width and the carry seed each opcode starts from.
package fa4_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // SUB is a + ~b + 1, so its seed carry is the "+1".
    function automatic logic init_carry(input alu_op_t op, input logic cin);
        logic c;
        case (op)
            ADD:     c = cin;
            SUB:     c = 1'b1;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic op_uses_carry(input alu_op_t op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/fa1_slice.sv
// One-bit ALU slice: full adder for ADD/SUB, plain gates for AND/OR.
// The carry output is always the full-adder majority; the caller decides whether to keep it.
module fa1_slice
    import fa4_pkg::*;
(
    input  logic    a_bit_i,
    input  logic    b_bit_i,
    input  logic    cin_i,
    input  alu_op_t op_i,
    output logic    s_o,
    output logic    cout_o
);

    always_comb begin
        s_o = 1'b0;
        case (op_i)
            ADD, SUB: s_o = a_bit_i ^ b_bit_i ^ cin_i;
            AND:      s_o = a_bit_i & b_bit_i;
            OR:       s_o = a_bit_i | b_bit_i;
            default:  s_o = 1'b0;
        endcase
    end

    assign cout_o = (a_bit_i & b_bit_i) | (a_bit_i & cin_i) | (b_bit_i & cin_i);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial execute engine: runs one fa1_slice LSB-first over WIDTH cycles behind a
// start/done handshake, and publishes result/carry/zero only when an operation completes.
module serial_alu_sequencer
    import fa4_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  alu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             zero_o
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cin_q, cin_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             zero_q, zero_d;

    logic             slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;

    fa1_slice u_slice (
        .a_bit_i (a_sh_q[0]),
        .b_bit_i (b_sh_q[0]),
        .cin_i   (carry_q),
        .op_i    (op_q),
        .s_o     (slice_s),
        .cout_o  (slice_cout)
    );

    // Result shifter holds only the upper WIDTH-1 bits; the newest slice bit completes the word.
    assign res_next = {slice_s, res_sh_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cin_d       = cin_q;
        op_d        = op_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    op_d    = op_i;
                    cin_d   = carry_in_i;
                    a_sh_d  = a_i;
                    b_sh_d  = (op_i == SUB) ? ~b_i : b_i;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                carry_d = init_carry(op_q, cin_q);
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next[WIDTH-1:1];
                if (op_uses_carry(op_q)) begin
                    carry_d = slice_cout;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish the finished word and flags so they are valid in the DONE cycle.
                    result_d    = res_next;
                    carry_out_d = op_uses_carry(op_q) ? slice_cout : 1'b0;
                    zero_d      = (res_next == '0);
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cin_q       <= 1'b0;
            op_q        <= ADD;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end

    assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = result_q;
    assign carry_out_o = carry_out_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer: directed vector table, handshake corner
// cases and randomized operations against an arithmetic reference model.
module tb_serial_alu_sequencer;
    import fa4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    alu_op_t    op;
    logic [3:0] a, b;
    logic       cin;
    logic       busy, done, co, zero;
    logic [3:0] result;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    serial_alu_sequencer #(.WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .carry_in_i  (cin),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .carry_out_o (co),
        .zero_o      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        alu_op_t    op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_res;
        logic       exp_co;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[6];

    // Reference: {carry_out, result} straight from integer arithmetic.
    function automatic logic [4:0] model(input alu_op_t o, input logic [3:0] x,
                                         input logic [3:0] y, input logic c);
        logic [4:0] r;
        case (o)
            ADD:     r = {1'b0, x} + {1'b0, y} + {4'b0, c};
            SUB:     r = {(x >= y), 4'(x - y)};
            AND:     r = {1'b0, x & y};
            default: r = {1'b0, x | y};
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Issue one op, scramble the inputs right after the accept edge, and return in the
    // DONE cycle with lat = clock edges from the accept edge (inclusive) to done.
    task automatic run_op(input alu_op_t o, input logic [3:0] x, input logic [3:0] y,
                          input logic c, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op  = alu_op_t'(2'($urandom));
        a   = 4'($urandom);
        b   = 4'($urandom);
        cin = 1'($urandom);
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int         lat, cnt, t1, t2;
        logic [3:0] r;
        logic [4:0] m;
        alu_op_t    ro;
        logic [3:0] ra, rb;
        logic       rc;
        bit         seen;

        vecs[0] = '{ADD, 4'h7, 4'h9, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[1] = '{SUB, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs[2] = '{SUB, 4'h5, 4'h5, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[3] = '{AND, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0};
        vecs[4] = '{OR,  4'hC, 4'hA, 1'b0, 4'hE, 1'b0, 1'b0};
        vecs[5] = '{ADD, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset carry", co, 0);
        chk("reset zero", zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            $display("vec %0d op=%0d a=%h b=%h cin=%0d -> result=%h co=%0d zero=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, result, co, zero, lat);
            chk($sformatf("vec%0d latency", i), lat, 6);
            chk($sformatf("vec%0d result", i), result, vecs[i].exp_res);
            chk($sformatf("vec%0d carry", i), co, vecs[i].exp_co);
            chk($sformatf("vec%0d zero", i), zero, vecs[i].exp_zero);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        op = ADD; a = 4'h3; b = 4'h4; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy after accept", busy, 1);
        @(negedge clk);
        op = OR; a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0; r = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) begin cnt++; r = result; end
        end
        $display("ignored-start op: done pulses=%0d result=%h", cnt, r);
        chk("ignored start done count", cnt, 1);
        chk("ignored start result", r, 4'h7);

        // Back-to-back: start held high across DONE.
        @(negedge clk);
        op = SUB; a = 4'h9; b = 4'h2; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 op = ADD; a = 4'h8; b = 4'h9; cin = 1'b1;
        t1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin t1 = cyc; break; end
        end
        chk("b2b first done seen", (t1 >= 0), 1);
        chk("b2b first result", result, 4'h7);
        chk("b2b first carry", co, 1);
        @(posedge clk);
        #1 start = 1'b0; op = AND; a = 4'h0; b = 4'h0; cin = 1'b0;
        @(negedge clk);
        chk("b2b busy after done", busy, 1);
        t2 = -100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin t2 = cyc; break; end
        end
        $display("back-to-back: second result=%h co=%0d spacing=%0d", result, co, t2 - t1);
        chk("b2b done spacing", t2 - t1, 6);
        chk("b2b second result", result, 4'h2);
        chk("b2b second carry", co, 1);
        chk("b2b second zero", zero, 0);

        // Reset during RUN bit 2.
        @(negedge clk);
        op = ADD; a = 4'h5; b = 4'h6; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun reset busy", busy, 0);
        chk("midrun reset done", done, 0);
        chk("midrun reset result", result, 0);
        chk("midrun reset carry", co, 0);
        chk("midrun reset zero", zero, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrun reset no done", seen, 0);
        rst = 1'b0;
        run_op(ADD, 4'h1, 4'h1, 1'b0, lat);
        $display("post-reset ADD 1+1 -> result=%h lat=%0d", result, lat);
        chk("post reset latency", lat, 6);
        chk("post reset result", result, 4'h2);
        chk("post reset carry", co, 0);

        for (int i = 0; i < 30; i++) begin
            ro = alu_op_t'(2'($urandom));
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            m  = model(ro, ra, rb, rc);
            run_op(ro, ra, rb, rc, lat);
            $display("rand %0d op=%0d a=%h b=%h cin=%0d -> result=%h co=%0d zero=%0d",
                     i, ro, ra, rb, rc, result, co, zero);
            chk($sformatf("rand%0d latency", i), lat, 6);
            chk($sformatf("rand%0d result", i), result, m[3:0]);
            chk($sformatf("rand%0d carry", i), co, m[4]);
            chk($sformatf("rand%0d zero", i), zero, (m[3:0] == 4'h0));
        end

        // Outputs hold through IDLE.
        repeat (3) @(negedge clk);
        chk("hold result", result, m[3:0]);
        chk("hold carry", co, m[4]);
        chk("hold done low", done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
